icache_intc_req_router: RTL and testbench
=========================================

Name: icache_intc_req_router

Overview:
- Request-side companion of the instruction-cache interconnect response arbitration tree.
- Takes one processor fetch request and decodes the target cache bank from the address.
- Holds the request in a one-entry registered stage and presents it to that bank only, with a req/gnt handshake on both sides.
- Tracks outstanding fetches so that the number in flight never exceeds what the response path is sized for.

Parameters:
- N_CACHE_BANKS, 16, number of cache banks; power of two, >=1.
- ADDR_WIDTH, 32, fetch address width.
- OFFSET_BITS, 4, number of address LSBs below the bank-index field (line offset).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests; >=1.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- request_i, input, 1, processor fetch request.
- address_i, input, ADDR_WIDTH, processor fetch address.
- grant_o, output, 1, request accepted this cycle.
- request_o, output, N_CACHE_BANKS, per-bank request; at most one bit high.
- address_o, output, N_CACHE_BANKS x ADDR_WIDTH, per-bank address; all lanes carry the buffered address.
- grant_i, input, N_CACHE_BANKS, per-bank grant.
- response_i, input, 1, aggregated response from the response tree; one pulse per completed fetch.
- outstanding_o, output, $clog2(MAX_OUTSTANDING+1), current in-flight count.
- error_o, output, 1, sticky protocol-error flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: request_o=0, address_o=0, outstanding_o=0, error_o=0, buffer EMPTY. grant_o is 1 when request_i is high and the reset has been released.
- Bank index: address_i[OFFSET_BITS +: log2(N_CACHE_BANKS)].
- When N_CACHE_BANKS=1 the index is constant 0 and no address bits are used.
- Buffer FSM has two states:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on pop without accept.
  - FULL -> FULL on pop with accept (back-to-back).
  - FULL holds while the selected bank's grant_i=0.
- pop = buffer FULL && grant_i[buf_bank].
- grant_o (combinational) = request_i && outstanding_o < MAX_OUTSTANDING && (EMPTY || pop).
- accept = request_i && grant_o. On accept the buffer captures address_i and the decoded bank index.
- request_o[buf_bank] = 1 while FULL; all other bits are 0.
- Latency: a request accepted at cycle t drives request_o from cycle t+1. Bank grant in the same cycle pops it, giving 1-cycle routing latency.
- Outstanding counter:
  - +1 on accept; -1 on response_i.
  - Accept and response_i in the same cycle: counter unchanged.
  - Saturates at MAX_OUTSTANDING; grant_o blocks, so the counter never exceeds it.
  - response_i while the counter is 0: counter stays 0 and error_o is set.
- error_o is also set if a grant_i bit is high for a bank with request_o low. error_o clears only on rst.
- Buffered address and request are held stable while waiting for grant_i. request_o never drops before pop.
- request_i may drop without being granted. No state change in that case.
- Reset mid-operation: the buffer is discarded and the counter is cleared. Responses already in flight for discarded requests raise error_o if they arrive with the counter at 0.

Test Plan:
- Single fetch, N=16, OFFSET_BITS=4, address 0x0000_0350 -> grant_o=1 at t. request_o=16'h0020 and address_o=0x350 at t+1. grant_i[5]=1 at t+1 pops the buffer. response_i at t+3 returns outstanding_o to 0.
- Bank stall: address 0x1A0, grant_i=0 for 4 cycles -> request_o[10] held high 4 cycles with the address stable. A second request_i in that window sees grant_o=0. grant_i[10] then pops the buffer and the second request is granted in the same cycle.
- Outstanding limit, MAX_OUTSTANDING=2, banks always granting, no responses -> first two requests granted, third held with grant_o=0. One response_i pulse -> third granted the next cycle; outstanding_o stays 2.
- Simultaneous accept + response with outstanding_o=1 -> grant_o=1, outstanding_o remains 1.
- Protocol error: response_i with outstanding_o=0 -> error_o=1 from the next cycle and sticky through 10 idle cycles. rst clears it.
- Reset mid-operation: buffer FULL for bank 3 with outstanding_o=2, rst for one cycle -> request_o=0 and outstanding_o=0 next cycle. A new request to bank 7 is then routed normally. N=1 build routes every address to request_o[0].

Source files
------------

// File: rtl/icache_intc_req_router.sv
// icache_intc_req_router: decodes the fetch bank, buffers one request and bounds outstanding fetches
module icache_intc_req_router #(
  parameter int N_CACHE_BANKS   = 16,
  parameter int ADDR_WIDTH      = 32,
  parameter int OFFSET_BITS     = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      request_i,
  input  logic [ADDR_WIDTH-1:0]                     address_i,
  output logic                                      grant_o,
  output logic [N_CACHE_BANKS-1:0]                  request_o,
  output logic [N_CACHE_BANKS-1:0][ADDR_WIDTH-1:0]  address_o,
  input  logic [N_CACHE_BANKS-1:0]                  grant_i,
  input  logic                                      response_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]      outstanding_o,
  output logic                                      error_o
);
  localparam int BW = N_CACHE_BANKS > 1 ? $clog2(N_CACHE_BANKS) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t                r_state;
  logic [BW-1:0]         r_bank;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CW-1:0]         r_cnt;
  logic                  r_err;
  logic [BW-1:0]         w_bank;
  logic                  w_pop;
  logic                  w_accept;
  logic                  w_stray;
  // a single bank has no index field, so no address bits select it
  if (N_CACHE_BANKS > 1) begin : g_idx
    assign w_bank = address_i[OFFSET_BITS +: BW];
  end else begin : g_noidx
    assign w_bank = '0;
  end
  assign w_pop         = (r_state == FULL) && grant_i[r_bank];
  assign grant_o       = !rst && request_i && (r_cnt < CW'(MAX_OUTSTANDING)) && ((r_state == EMPTY) || w_pop);
  assign w_accept      = request_i && grant_o;
  assign request_o     = (r_state == FULL) ? (N_CACHE_BANKS'(1) << r_bank) : '0;
  assign address_o     = {N_CACHE_BANKS{r_addr}};
  assign w_stray       = |(grant_i & ~request_o);
  assign outstanding_o = r_cnt;
  assign error_o       = r_err;
  // buffer FSM, captured request, in-flight counter and sticky protocol error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_bank  <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_accept ? FULL : (w_pop ? EMPTY : r_state);
      if (w_accept) begin
        r_addr <= address_i;
        r_bank <= w_bank;
      end
      r_cnt <= (w_accept && !response_i) ? r_cnt + 1'b1 :
               (response_i && !w_accept && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
      r_err <= r_err | (response_i && r_cnt == '0) | w_stray;
    end
  end
endmodule

// File: tb/tb_icache_intc_req_router.sv
// tb_icache_intc_req_router: scoreboard bench for the fetch request router
module tb_icache_intc_req_router;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              request_i = 1'b0;
  logic [31:0]       address_i = '0;
  logic              grant_o;
  logic [15:0]       request_o;
  logic [15:0][31:0] address_o;
  logic [15:0]       grant_i;
  logic              response_i = 1'b0;
  logic [1:0]        outstanding_o;
  logic              error_o;
  logic [15:0]       grant_drv = '0;
  logic              auto_gnt = 1'b0;
  logic              req1 = 1'b0;
  logic [31:0]       addr1 = '0;
  logic              gnt_o1;
  logic [0:0]        req_o1;
  logic [0:0][31:0]  addr_o1;
  logic [1:0]        out1;
  logic              err1;
  typedef struct {int bank; logic [31:0] addr;} ent_t;
  ent_t sbq[$];
  ent_t e;
  int checks = 0;
  int errors = 0;

  assign grant_i = auto_gnt ? request_o : grant_drv;

  always #5 clk = ~clk;

  icache_intc_req_router dut (
    .clk(clk), .rst(rst), .request_i(request_i), .address_i(address_i),
    .grant_o(grant_o), .request_o(request_o), .address_o(address_o),
    .grant_i(grant_i), .response_i(response_i),
    .outstanding_o(outstanding_o), .error_o(error_o)
  );

  icache_intc_req_router #(.N_CACHE_BANKS(1)) dut1 (
    .clk(clk), .rst(rst), .request_i(req1), .address_i(addr1),
    .grant_o(gnt_o1), .request_o(req_o1), .address_o(addr_o1),
    .grant_i(req_o1), .response_i(1'b0),
    .outstanding_o(out1), .error_o(err1)
  );

  always @(negedge clk) begin
    if (rst) sbq.delete();
    else begin
      if (|(grant_i & request_o)) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_pop unexpected routed request_o=%h", request_o);
        end else begin
          e = sbq.pop_front();
          if (request_o !== (16'h1 << e.bank) || address_o[e.bank] !== e.addr) begin
            errors++;
            $display("FAIL sb_route request_o=%h addr=%h expected bank %0d addr=%h",
                     request_o, address_o[e.bank], e.bank, e.addr);
          end
        end
      end
      if (request_i && grant_o) sbq.push_back('{bank: int'(address_i[7:4]), addr: address_i});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (request_o !== 16'h0 || address_o !== '0 || outstanding_o !== 2'd0 || error_o !== 1'b0 || grant_o !== 1'b0) begin
      errors++;
      $display("FAIL reset req=%h out=%0d err=%b gnt=%b expected 0 0 0 0", request_o, outstanding_o, error_o, grant_o);
    end
  endtask

  task automatic test_single;
    tick;
    request_i = 1'b1;
    address_i = 32'h350;
    @(negedge clk);
    checks++;
    if (grant_o !== 1'b1) begin errors++; $display("FAIL single_grant got %b expected 1", grant_o); end
    tick;
    request_i = 1'b0;
    grant_drv = 16'h0020;
    @(negedge clk);
    checks++;
    if (request_o !== 16'h0020 || address_o[5] !== 32'h350 || outstanding_o !== 2'd1) begin
      errors++;
      $display("FAIL single_route req=%h addr=%h out=%0d expected 0020 350 1", request_o, address_o[5], outstanding_o);
    end
    tick;
    grant_drv = '0;
    @(negedge clk);
    checks++;
    if (request_o !== 16'h0) begin errors++; $display("FAIL single_popped req=%h expected 0", request_o); end
    tick;
    response_i = 1'b1;
    tick;
    response_i = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding_o !== 2'd0 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL single_resp out=%0d err=%b expected 0 0", outstanding_o, error_o);
    end
  endtask

  task automatic test_stall;
    tick;
    request_i = 1'b1;
    address_i = 32'h1A0;
    @(negedge clk);
    checks++;
    if (grant_o !== 1'b1) begin errors++; $display("FAIL stall_grant got %b expected 1", grant_o); end
    tick;
    request_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        request_i = 1'b1;
        address_i = 32'h0F0;
      end
      @(negedge clk);
      checks++;
      if (request_o !== 16'h0400 || address_o[10] !== 32'h1A0) begin
        errors++;
        $display("FAIL stall_hold cycle %0d req=%h addr=%h expected 0400 1a0", i, request_o, address_o[10]);
      end
      if (i == 3) begin
        checks++;
        if (grant_o !== 1'b0) begin errors++; $display("FAIL stall_block got %b expected 0", grant_o); end
      end
      tick;
    end
    grant_drv = 16'h0400;
    @(negedge clk);
    checks++;
    if (grant_o !== 1'b1) begin errors++; $display("FAIL stall_b2b got %b expected 1", grant_o); end
    tick;
    request_i = 1'b0;
    grant_drv = 16'h8000;
    @(negedge clk);
    checks++;
    if (request_o !== 16'h8000 || outstanding_o !== 2'd2) begin
      errors++;
      $display("FAIL stall_second req=%h out=%0d expected 8000 2", request_o, outstanding_o);
    end
    tick;
    grant_drv = '0;
    response_i = 1'b1;
    tick;
    tick;
    response_i = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding_o !== 2'd0) begin errors++; $display("FAIL stall_drain out=%0d expected 0", outstanding_o); end
  endtask

  task automatic test_limit;
    auto_gnt = 1'b1;
    tick;
    request_i = 1'b1;
    address_i = 32'h000;
    @(negedge clk);
    checks++;
    if (grant_o !== 1'b1) begin errors++; $display("FAIL limit_first got %b expected 1", grant_o); end
    tick;
    address_i = 32'h010;
    @(negedge clk);
    checks++;
    if (grant_o !== 1'b1) begin errors++; $display("FAIL limit_second got %b expected 1", grant_o); end
    tick;
    address_i = 32'h020;
    @(negedge clk);
    checks++;
    if (grant_o !== 1'b0 || outstanding_o !== 2'd2) begin
      errors++;
      $display("FAIL limit_block gnt=%b out=%0d expected 0 2", grant_o, outstanding_o);
    end
    tick;
    response_i = 1'b1;
    @(negedge clk);
    checks++;
    if (grant_o !== 1'b0) begin errors++; $display("FAIL limit_resp_cycle got %b expected 0", grant_o); end
    tick;
    response_i = 1'b0;
    @(negedge clk);
    checks++;
    if (grant_o !== 1'b1) begin errors++; $display("FAIL limit_third got %b expected 1", grant_o); end
    tick;
    request_i = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding_o !== 2'd2) begin errors++; $display("FAIL limit_count out=%0d expected 2", outstanding_o); end
    response_i = 1'b1;
    tick;
    tick;
    response_i = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding_o !== 2'd0) begin errors++; $display("FAIL limit_drain out=%0d expected 0", outstanding_o); end
  endtask

  task automatic test_simul;
    tick;
    request_i = 1'b1;
    address_i = 32'h040;
    @(negedge clk);
    checks++;
    if (grant_o !== 1'b1) begin errors++; $display("FAIL simul_first got %b expected 1", grant_o); end
    tick;
    request_i = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding_o !== 2'd1) begin errors++; $display("FAIL simul_one out=%0d expected 1", outstanding_o); end
    tick;
    request_i = 1'b1;
    address_i = 32'h050;
    response_i = 1'b1;
    @(negedge clk);
    checks++;
    if (grant_o !== 1'b1) begin errors++; $display("FAIL simul_grant got %b expected 1", grant_o); end
    tick;
    request_i = 1'b0;
    response_i = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding_o !== 2'd1 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL simul_count out=%0d err=%b expected 1 0", outstanding_o, error_o);
    end
    tick;
    response_i = 1'b1;
    tick;
    response_i = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding_o !== 2'd0) begin errors++; $display("FAIL simul_drain out=%0d expected 0", outstanding_o); end
  endtask

  task automatic test_error;
    tick;
    response_i = 1'b1;
    tick;
    response_i = 1'b0;
    @(negedge clk);
    checks++;
    if (error_o !== 1'b1 || outstanding_o !== 2'd0) begin
      errors++;
      $display("FAIL error_set err=%b out=%0d expected 1 0", error_o, outstanding_o);
    end
    for (int i = 0; i < 10; i++) begin
      tick;
      @(negedge clk);
      checks++;
      if (error_o !== 1'b1) begin errors++; $display("FAIL error_sticky cycle %0d got %b expected 1", i, error_o); end
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (error_o !== 1'b0) begin errors++; $display("FAIL error_clear got %b expected 0", error_o); end
  endtask

  task automatic test_reset_mid;
    auto_gnt = 1'b1;
    tick;
    request_i = 1'b1;
    address_i = 32'h000;
    tick;
    address_i = 32'h030;
    tick;
    auto_gnt = 1'b0;
    grant_drv = '0;
    request_i = 1'b0;
    @(negedge clk);
    checks++;
    if (request_o !== 16'h0008 || outstanding_o !== 2'd2) begin
      errors++;
      $display("FAIL mid_setup req=%h out=%0d expected 0008 2", request_o, outstanding_o);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (request_o !== 16'h0 || outstanding_o !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset req=%h out=%0d expected 0 0", request_o, outstanding_o);
    end
    auto_gnt = 1'b1;
    tick;
    request_i = 1'b1;
    address_i = 32'h070;
    @(negedge clk);
    checks++;
    if (grant_o !== 1'b1) begin errors++; $display("FAIL mid_regrant got %b expected 1", grant_o); end
    tick;
    request_i = 1'b0;
    @(negedge clk);
    checks++;
    if (request_o !== 16'h0080 || outstanding_o !== 2'd1) begin
      errors++;
      $display("FAIL mid_route req=%h out=%0d expected 0080 1", request_o, outstanding_o);
    end
    tick;
    response_i = 1'b1;
    tick;
    response_i = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding_o !== 2'd0 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_drain out=%0d err=%b expected 0 0", outstanding_o, error_o);
    end
  endtask

  task automatic test_single_bank;
    tick;
    req1 = 1'b1;
    addr1 = 32'h350;
    @(negedge clk);
    checks++;
    if (gnt_o1 !== 1'b1) begin errors++; $display("FAIL n1_grant got %b expected 1", gnt_o1); end
    tick;
    addr1 = 32'hFFF0;
    @(negedge clk);
    checks++;
    if (req_o1 !== 1'b1 || addr_o1[0] !== 32'h350 || gnt_o1 !== 1'b1) begin
      errors++;
      $display("FAIL n1_first req=%b addr=%h gnt=%b expected 1 350 1", req_o1, addr_o1[0], gnt_o1);
    end
    tick;
    req1 = 1'b0;
    @(negedge clk);
    checks++;
    if (req_o1 !== 1'b1 || addr_o1[0] !== 32'hFFF0 || out1 !== 2'd2) begin
      errors++;
      $display("FAIL n1_second req=%b addr=%h out=%0d expected 1 fff0 2", req_o1, addr_o1[0], out1);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_stall;
    test_limit;
    test_simul;
    test_error;
    test_reset_mid;
    test_single_bank;
    tick;
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL sb_leftover %0d entries expected 0", sbq.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
